// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control: multicycle RV32 ALU-subset control FSM with IR and counter
// Revision: 1.0
// ============================================================================
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   imem_ready,
  input  logic [31:0]            instr,
  output logic                   imem_req,
  output logic                   ir_write,
  output logic [31:0]            ir,
  output logic [2:0]             alu_op,
  output logic                   alu_src_imm,
  output logic                   reg_write,
  output logic                   pc_write,
  output logic                   illegal,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [2:0] C_ALU_ADD = 3'd0;
  localparam logic [2:0] C_ALU_SUB = 3'd1;
  localparam logic [2:0] C_ALU_AND = 3'd2;
  localparam logic [2:0] C_ALU_OR  = 3'd3;
  localparam logic [2:0] C_ALU_XOR = 3'd4;
  localparam logic [2:0] C_ALU_SLL = 3'd5;
  localparam logic [2:0] C_ALU_SRL = 3'd6;
  localparam logic [2:0] C_ALU_SLT = 3'd7;

  localparam logic [6:0] C_OP_R = 7'b0110011;
  localparam logic [6:0] C_OP_I = 7'b0010011;

  state_t                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [2:0] dec_op;
  logic       dec_imm;
  logic       dec_ok;

  assign w_funct3 = ir_q[14:12];
  assign w_funct7 = ir_q[31:25];

  // Decode is purely a function of the latched IR, so it is stable across EXECUTE/WRITEBACK.
  always_comb begin
    dec_op  = C_ALU_ADD;
    dec_imm = 1'b0;
    dec_ok  = 1'b0;
    if (ir_q[6:0] == C_OP_R) begin
      case (w_funct3)
        3'b000: begin
          if (w_funct7 == 7'b0000000) begin
            dec_op = C_ALU_ADD; dec_ok = 1'b1;
          end else if (w_funct7 == 7'b0100000) begin
            dec_op = C_ALU_SUB; dec_ok = 1'b1;
          end
        end
        3'b111: begin dec_op = C_ALU_AND; dec_ok = 1'b1; end
        3'b110: begin dec_op = C_ALU_OR;  dec_ok = 1'b1; end
        3'b100: begin dec_op = C_ALU_XOR; dec_ok = 1'b1; end
        3'b010: begin dec_op = C_ALU_SLT; dec_ok = 1'b1; end
        3'b001: begin dec_op = C_ALU_SLL; dec_ok = (w_funct7 == 7'b0000000); end
        3'b101: begin dec_op = C_ALU_SRL; dec_ok = (w_funct7 == 7'b0000000); end
        default: ;
      endcase
    end else if (ir_q[6:0] == C_OP_I) begin
      dec_imm = 1'b1;
      case (w_funct3)
        3'b000: begin dec_op = C_ALU_ADD; dec_ok = 1'b1; end
        3'b111: begin dec_op = C_ALU_AND; dec_ok = 1'b1; end
        3'b110: begin dec_op = C_ALU_OR;  dec_ok = 1'b1; end
        3'b100: begin dec_op = C_ALU_XOR; dec_ok = 1'b1; end
        3'b010: begin dec_op = C_ALU_SLT; dec_ok = 1'b1; end
        3'b001: begin dec_op = C_ALU_SLL; dec_ok = (w_funct7 == 7'b0000000); end
        3'b101: begin dec_op = C_ALU_SRL; dec_ok = (w_funct7 == 7'b0000000); end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    illegal_d   = illegal_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    alu_op      = C_ALU_ADD;
    alu_src_imm = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          ir_d     = instr;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXECUTE: begin
        alu_op      = dec_op;
        alu_src_imm = dec_imm;
        state_d     = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        alu_op      = dec_op;
        alu_src_imm = dec_imm;
        pc_write    = 1'b1;
        reg_write   = (ir_q[11:7] != 5'd0);
        count_d     = count_q + 1'b1;
        state_d     = run ? S_FETCH : S_IDLE;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_q      <= 32'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign ir            = ir_q;
  assign illegal       = illegal_q;
  assign state         = state_q;
  assign retired_count = count_q;

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: COUNT_WIDTH, default 32, width of retired_count.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 run  input  1  1 = execute instructions; 0 = return to IDLE after current instruction.
REQ-005 imem_ready  input  1  instruction memory has valid data on instr this cycle.
REQ-006 instr  input  32  instruction word from instruction memory.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 ir_write  output  1  one-cycle pulse when instr is latched into the internal instruction register.
REQ-009 ir  output  32  latched instruction word, which supplies rs1/rs2/rd/imm fields to the datapath.
REQ-010 alu_op  output  3  shared ALU encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7.
REQ-011 alu_src_imm  output  1  0 = ALU b from rs2; 1 = ALU b from sign-extended ir[31:20].
REQ-012 reg_write  output  1  register file write enable.
REQ-013 pc_write  output  1  PC load enable (pc <= pc + 4).
REQ-014 illegal  output  1  sticky flag for an undecodable instruction.
REQ-015 state  output  3  current FSM state code.
REQ-016 retired_count  output  COUNT_WIDTH  number of completed instructions.

Function
REQ-017 States SHALL be encoded IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-018 IDLE SHALL move to FETCH when run=1; otherwise it SHALL stay in IDLE.
REQ-019 FETCH SHALL drive imem_req=1; when imem_ready=1, it SHALL drive ir_write=1, latch instr into ir at that edge and move to DECODE; otherwise it SHALL stay in FETCH with ir_write=0.
REQ-020 After ir is latched, changes on instr SHALL have no effect until the next FETCH handshake.
REQ-021 R-type decode (opcode 0110011) SHALL be: funct3 000 with funct7 0000000 -> ADD; funct3 000 with funct7 0100000 -> SUB; 111 -> AND; 110 -> OR; 100 -> XOR; 010 -> SLT; 001 with funct7 0 -> SLL; 101 with funct7 0 -> SRL; all with alu_src_imm=0.
REQ-022 I-type decode (opcode 0010011) SHALL be: funct3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; 001 -> SLL and 101 -> SRL only when ir[31:25]=0; all with alu_src_imm=1.
REQ-023 Any other encoding SHALL be illegal.
REQ-024 DECODE SHALL move to HALT and set illegal=1 on an illegal encoding; otherwise it SHALL move to EXECUTE.
REQ-025 EXECUTE SHALL always move to WRITEBACK.
REQ-026 alu_op and alu_src_imm SHALL hold their decoded values for the whole of EXECUTE and WRITEBACK; in all other states they SHALL be ADD and 0.
REQ-027 WRITEBACK SHALL drive pc_write=1 for exactly one cycle.
REQ-028 WRITEBACK SHALL drive reg_write=1 for exactly one cycle, except reg_write=0 when ir[11:7]=0.
REQ-029 WRITEBACK SHALL increment retired_count by 1, wrapping modulo 2^COUNT_WIDTH.
REQ-030 From WRITEBACK the next state SHALL be FETCH when run=1 and IDLE when run=0.
REQ-031 run=0 in FETCH/DECODE/EXECUTE SHALL NOT abort the current instruction.
REQ-032 HALT SHALL hold with imem_req=0, pc_write=0, reg_write=0; only reset exits HALT.
REQ-033 Latency with imem_ready constantly 1 SHALL be 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK); each cycle of imem_ready=0 in FETCH adds 1 cycle.
REQ-034 imem_req, ir_write, reg_write and pc_write SHALL be 0 in every state not named above.

Reset
REQ-035 reset=0 SHALL force, without waiting for clk: state=IDLE, ir=0, alu_op=ADD, alu_src_imm=0, imem_req=0, ir_write=0, reg_write=0, pc_write=0, illegal=0, retired_count=0.
REQ-036 Reset asserted mid-instruction SHALL discard that instruction: no pc_write, reg_write or count increment for it.
REQ-037 After reset deasserts, the first transition SHALL occur on the next rising clk edge per REQ-018.

Verification
REQ-038 run=1, imem_ready=1, instr=32'h005303b3 -> state 1,2,3,4; alu_op=ADD, alu_src_imm=0 in EXECUTE; WRITEBACK reg_write=1, pc_write=1; retired_count=1.
REQ-039 Next instr=32'h40848533 -> alu_op=SUB in EXECUTE; retired_count=2 after WRITEBACK.
REQ-040 imem_ready=0 for 3 cycles in FETCH -> state stays 1, imem_req=1, ir_write=0; then ready=1 -> ir_write pulse and DECODE; instruction takes 7 cycles total.
REQ-041 instr=32'h00100013 (addi x0) -> alu_src_imm=1, alu_op=ADD, reg_write=0, pc_write=1.
REQ-042 instr=32'hffffffff -> DECODE then HALT, illegal=1, pc_write never 1; 10 further cycles stay in HALT; reset clears illegal.
REQ-043 Reset pulsed during EXECUTE -> immediate state=0 with all outputs 0 and retired_count unchanged-to-0; run=0 during WRITEBACK -> IDLE next cycle.
